// File: rtl/program_counter_pkg.sv
// Shared widths for the 16-bit program counter built from two byte halves.
package program_counter_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PC_W   = 16;

endpackage

// File: rtl/pc_byte_reg.sv
// Byte-wide register with asynchronous clear and a synchronous load enable.
module pc_byte_reg
    import program_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/program_counter.sv
// 16-bit program counter with staged high-byte jump target (PCHITMP) for atomic long jumps.
module program_counter
    import program_counter_pkg::*;
(
    input  logic              clk,
    input  logic              _MR,
    input  logic              _pc_in,
    input  logic              _pclo_in,
    input  logic              _pchitmp_in,
    input  logic [BYTE_W-1:0] D,
    output logic [BYTE_W-1:0] PCHI,
    output logic [BYTE_W-1:0] PCLO
);

    logic [BYTE_W-1:0] pchitmp;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_next;

    // Staging register; PCHI reads its pre-edge value during a long jump.
    pc_byte_reg u_pchitmp (
        .clk   (clk),
        .rst_n (_MR),
        .load  (!_pchitmp_in),
        .d     (D),
        .q     (pchitmp)
    );

    assign pc_inc = pc + PC_W'(1);

    // Long jump beats short jump beats increment.
    always_comb begin
        pc_next = pc_inc;
        if (!_pc_in) begin
            pc_next = {pchitmp, D};
        end else if (!_pclo_in) begin
            pc_next = {pc[PC_W-1:BYTE_W], D};
        end
    end

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    assign PCHI = pc[PC_W-1:BYTE_W];
    assign PCLO = pc[BYTE_W-1:0];

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

    logic       clk;
    logic       _MR;
    logic       _pc_in;
    logic       _pclo_in;
    logic       _pchitmp_in;
    logic [7:0] D;
    logic [7:0] PCHI;
    logic [7:0] PCLO;

    int tests_run;
    int tests_failed;

    program_counter dut (
        .clk         (clk),
        ._MR         (_MR),
        ._pc_in      (_pc_in),
        ._pclo_in    (_pclo_in),
        ._pchitmp_in (_pchitmp_in),
        .D           (D),
        .PCHI        (PCHI),
        .PCLO        (PCLO)
    );

    task automatic rise();
        clk = 1'b1;
        #5;
    endtask

    task automatic fall();
        clk = 1'b0;
        #5;
    endtask

    task automatic pulse();
        rise();
        fall();
    endtask

    task automatic idle_controls();
        _pc_in      = 1'b1;
        _pclo_in    = 1'b1;
        _pchitmp_in = 1'b1;
    endtask

    task automatic test_reset();
        clk = 1'b0;
        _MR = 1'b0;
        idle_controls();
        D = 8'h5A;
        #2;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_no_clock: got %h expected 0000", {PCHI, PCLO});
        end
        _pc_in = 1'b0;
        _pchitmp_in = 1'b0;
        pulse();
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_held_pulses: got %h expected 0000", {PCHI, PCLO});
        end
        idle_controls();
        _MR = 1'b1;
        #2;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_release_no_edge: got %h expected 0000", {PCHI, PCLO});
        end
    endtask

    task automatic test_count();
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0001) begin
            tests_failed++;
            $display("FAIL count_first: got %h expected 0001", {PCHI, PCLO});
        end
        rise();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0002) begin
            tests_failed++;
            $display("FAIL count_second: got %h expected 0002", {PCHI, PCLO});
        end
        fall();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0002) begin
            tests_failed++;
            $display("FAIL count_falling_edge: got %h expected 0002", {PCHI, PCLO});
        end
    endtask

    task automatic test_tmp_load();
        D = 8'hFF;
        _pchitmp_in = 1'b0;
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0003) begin
            tests_failed++;
            $display("FAIL tmp_load_advance: got %h expected 0003", {PCHI, PCLO});
        end
        _pchitmp_in = 1'b1;
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0004) begin
            tests_failed++;
            $display("FAIL tmp_load_next: got %h expected 0004", {PCHI, PCLO});
        end
        D = 8'hAA;
        _pc_in = 1'b0;
        pulse();
        _pc_in = 1'b1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'hFFAA) begin
            tests_failed++;
            $display("FAIL long_jump: got %h expected FFAA", {PCHI, PCLO});
        end
    endtask

    task automatic test_short_jump();
        D = 8'hFE;
        _pclo_in = 1'b0;
        pulse();
        _pclo_in = 1'b1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL short_jump: got %h expected FFFE", {PCHI, PCLO});
        end
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL count_to_ffff: got %h expected FFFF", {PCHI, PCLO});
        end
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap: got %h expected 0000", {PCHI, PCLO});
        end
    endtask

    task automatic test_priority();
        // PCHITMP <= 0x12 while PC increments 0000 -> 0001.
        D = 8'h12;
        _pchitmp_in = 1'b0;
        pulse();
        _pchitmp_in = 1'b1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0001) begin
            tests_failed++;
            $display("FAIL tmp_load_increment: got %h expected 0001", {PCHI, PCLO});
        end
        D = 8'h34;
        _pc_in = 1'b0;
        _pclo_in = 1'b0;
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h1234) begin
            tests_failed++;
            $display("FAIL priority_pc_over_pclo: got %h expected 1234", {PCHI, PCLO});
        end
        D = 8'h56;
        _pchitmp_in = 1'b0;
        pulse();
        idle_controls();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h1256) begin
            tests_failed++;
            $display("FAIL priority_old_tmp: got %h expected 1256", {PCHI, PCLO});
        end
        D = 8'h00;
        _pc_in = 1'b0;
        pulse();
        _pc_in = 1'b1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h5600) begin
            tests_failed++;
            $display("FAIL tmp_captured_new: got %h expected 5600", {PCHI, PCLO});
        end
    endtask

    task automatic test_reset_mid_op();
        _pc_in = 1'b0;
        D = 8'h77;
        _MR = 1'b0;
        #1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_async_immediate: got %h expected 0000", {PCHI, PCLO});
        end
        pulse();
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_overrides_load: got %h expected 0000", {PCHI, PCLO});
        end
        // PCHITMP was cleared too: long jump after release yields {00, D}.
        _MR = 1'b1;
        #2;
        pulse();
        _pc_in = 1'b1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0077) begin
            tests_failed++;
            $display("FAIL load_after_release: got %h expected 0077", {PCHI, PCLO});
        end
    endtask

    task automatic test_full_range();
        logic [15:0] expected;
        logic [15:0] first_bad_got;
        logic [15:0] first_bad_exp;
        int          bad_count;
        idle_controls();
        _MR = 1'b0;
        #2;
        _MR = 1'b1;
        #2;
        expected = 16'h0000;
        bad_count = 0;
        first_bad_got = '0;
        first_bad_exp = '0;
        for (int i = 0; i < 65536 + 300; i++) begin
            pulse();
            expected = expected + 16'd1;
            if ({PCHI, PCLO} !== expected) begin
                if (bad_count == 0) begin
                    first_bad_got = {PCHI, PCLO};
                    first_bad_exp = expected;
                end
                bad_count++;
            end
        end
        tests_run++;
        if (bad_count != 0) begin
            tests_failed++;
            $display("FAIL full_range: %0d bad edges, first got %h expected %h",
                     bad_count, first_bad_got, first_bad_exp);
        end
        tests_run++;
        if ({PCHI, PCLO} !== 16'd300) begin
            tests_failed++;
            $display("FAIL full_range_end: got %h expected 012c", {PCHI, PCLO});
        end
        rise();
        _MR = 1'b0;
        #1;
        tests_run++;
        if ({PCHI, PCLO} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid_count: got %h expected 0000", {PCHI, PCLO});
        end
        fall();
        _MR = 1'b1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_count();
        test_tmp_load();
        test_short_jump();
        test_priority();
        test_reset_mid_op();
        test_full_range();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
